// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Desc     : Shared types and default widths for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int C_PC_W    = 10;
    localparam int C_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [C_PC_W-1:0]    pc;
        logic [C_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Desc     : Synchronous FIFO with flush; push and pop may coincide, even when full.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];

    // A pop frees the slot a simultaneous push lands in, so full does not block it.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Desc     : Single-outstanding req/gnt/rvalid fetch with FIFO buffering to decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int PC_W       = C_PC_W,
    parameter int INSTR_W    = C_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_in,
    output logic               pc_advance,
    input  logic               redirect,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               misalign
);

    localparam int c_ENTRY_W = PC_W + INSTR_W;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    fetch_state_t         r_state;
    logic [PC_W-1:0]      r_req_pc;
    logic                 r_addr_held;
    logic                 r_drop;
    logic                 r_misalign;

    logic [PC_W-1:0]      w_addr;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_CNT_W-1:0]   w_count_next;
    logic [c_ENTRY_W-1:0] w_head;

    // First REQ cycle forwards pc_in directly so a redirect target that arrives
    // together with the REQ entry is still honoured; later cycles hold the latch.
    assign w_addr = r_addr_held ? r_req_pc : pc_in;

    assign w_push = (r_state == WAIT) && mem_rvalid && !r_drop && !redirect;
    assign w_pop  = !w_empty && instr_ready && !redirect;

    always_comb begin
        w_count_next = w_count;
        if (redirect) begin
            w_count_next = '0;
        end else begin
            w_count_next = w_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_pc    <= '0;
            r_addr_held <= 1'b0;
            r_drop      <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!redirect && !w_full) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    r_req_pc <= w_addr;
                    if (w_addr[1:0] != 2'b00) begin
                        r_misalign <= 1'b1;
                    end
                    if (mem_gnt) begin
                        r_state     <= WAIT;
                        r_addr_held <= 1'b0;
                        r_drop      <= redirect;
                    end else if (redirect) begin
                        r_state     <= IDLE;
                        r_addr_held <= 1'b0;
                    end else begin
                        r_addr_held <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= (w_count_next < c_DEPTH) ? REQ : IDLE;
                    end else if (redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   ({r_req_pc, mem_rdata}),
        .pop   (w_pop),
        .flush (redirect),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign mem_req     = (r_state == REQ);
    assign mem_addr    = (r_state == REQ) ? w_addr : r_req_pc;
    assign pc_advance  = (r_state == REQ) && mem_gnt;
    assign misalign    = r_misalign;
    assign instr_valid = !w_empty;
    assign instr_pc    = w_head[c_ENTRY_W-1:INSTR_W];
    assign instr_out   = w_head[INSTR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Desc     : Randomised memory/PC-generator environment with an in-order PC scoreboard.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [PC_W-1:0]    pc_in;
    logic               pc_advance;
    logic               redirect;
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    instr_pc;
    logic               misalign;

    always #5 clk = ~clk;

    fetch_unit #(.FIFO_DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_advance(pc_advance),
        .redirect(redirect), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc), .misalign(misalign)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory responder state and knobs
    bit              pend;
    logic [PC_W-1:0] pend_addr;
    int              rv_cnt, gnt_cnt;
    int              max_gnt = 0, max_rv = 0;
    bit              gnt_block = 0, stale_rv = 0;

    // reference model: next in-order PC decode should see, sticky misalign
    logic [PC_W-1:0] exp_pc, redir_target, last_pop_pc;
    bit              exp_mis;
    int              grants, pops, advs, first_valid_cyc;
    int              adv_cycles[$];

    function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return (32'h9E37_79B9 * {22'd0, a}) ^ {a, 22'h2A5A5};
    endfunction

    task automatic do_reset(input logic [PC_W-1:0] start_pc);
        rst_n = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; pc_in = start_pc;
        pend = 1'b0; gnt_cnt = $urandom_range(max_gnt); stale_rv = 1'b0; gnt_block = 1'b0;
        exp_pc = start_pc; exp_mis = 1'b0; grants = 0; pops = 0; advs = 0;
        first_valid_cyc = -1; adv_cycles.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: called at the negedge with the test's inputs set, returns at the next negedge.
    task automatic cycle();
        logic            adv;
        logic            flushed;
        logic [PC_W-1:0] pc_next;
        total++;
        if (misalign !== exp_mis) begin
            bad++; $display("FAIL misalign_sticky: got %b want %b at cycle %0d", misalign, exp_mis, cyc);
        end
        if (mem_req === 1'b1) begin
            total++;
            if (pend) begin
                bad++; $display("FAIL single_outstanding: request while word pending at cycle %0d", cyc);
            end
            total++;
            if (mem_addr !== pc_in) begin
                bad++; $display("FAIL mem_addr: got %h want %h at cycle %0d", mem_addr, pc_in, cyc);
            end
            if (pc_in[1:0] != 2'b00) exp_mis = 1'b1;
        end
        if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;

        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (stale_rv) begin
            mem_rvalid = 1'b1;
        end else if (pend) begin
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1; mem_rdata = mem_word(pend_addr);
            end else begin
                rv_cnt--;
            end
        end
        if (mem_req === 1'b1 && !gnt_block) begin
            if (gnt_cnt == 0) mem_gnt = 1'b1;
            else gnt_cnt--;
        end
        #1;
        adv = pc_advance;
        total++;
        if (pc_advance !== (mem_req & mem_gnt)) begin
            bad++; $display("FAIL pc_advance: got %b want %b at cycle %0d", pc_advance, mem_req & mem_gnt, cyc);
        end
        if (adv === 1'b1) begin advs++; adv_cycles.push_back(cyc); end

        if (instr_valid === 1'b1 && instr_ready && !redirect) begin
            total++;
            if (instr_pc !== exp_pc) begin
                bad++; $display("FAIL instr_pc: got %h want %h at cycle %0d", instr_pc, exp_pc, cyc);
            end
            total++;
            if (instr_out !== mem_word(exp_pc)) begin
                bad++; $display("FAIL instr_out: got %h want %h at cycle %0d", instr_out, mem_word(exp_pc), cyc);
            end
            last_pop_pc = instr_pc; pops++; exp_pc = exp_pc + 10'd4;
        end

        if (mem_rvalid && !stale_rv) pend = 1'b0;
        if (mem_req === 1'b1 && mem_gnt) begin
            grants++; pend = 1'b1; pend_addr = mem_addr;
            rv_cnt = $urandom_range(max_rv); gnt_cnt = $urandom_range(max_gnt);
        end

        pc_next = pc_in;
        if (redirect) begin
            pc_next = redir_target; exp_pc = redir_target;
        end else if (adv === 1'b1) begin
            pc_next = pc_in + 10'd4;
        end
        flushed = redirect;
        @(posedge clk); #1;
        pc_in = pc_next; redirect = 1'b0; cyc++;
        if (flushed) begin
            total++;
            if (instr_valid !== 1'b0) begin
                bad++; $display("FAIL flush_valid: got %b want 0 at cycle %0d", instr_valid, cyc);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        total++; if (mem_req !== 1'b0)     begin bad++; $display("FAIL %s mem_req: got %b want 0", tag, mem_req); end
        total++; if (mem_addr !== '0)      begin bad++; $display("FAIL %s mem_addr: got %h want 0", tag, mem_addr); end
        total++; if (pc_advance !== 1'b0)  begin bad++; $display("FAIL %s pc_advance: got %b want 0", tag, pc_advance); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL %s instr_valid: got %b want 0", tag, instr_valid); end
        total++; if (instr_out !== '0)     begin bad++; $display("FAIL %s instr_out: got %h want 0", tag, instr_out); end
        total++; if (instr_pc !== '0)      begin bad++; $display("FAIL %s instr_pc: got %h want 0", tag, instr_pc); end
        total++; if (misalign !== 1'b0)    begin bad++; $display("FAIL %s misalign: got %b want 0", tag, misalign); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_in = 10'h3FC; redirect = 1'b0; instr_ready = 1'b1;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = '1;
        #1;
        check_all_zero("reset");
        max_gnt = 0; max_rv = 0;
        do_reset(10'h000);
        total++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release: got req=%b valid=%b want 0/0", mem_req, instr_valid);
        end
    endtask

    task automatic test_zero_wait();
        int req_cyc = -1;
        max_gnt = 0; max_rv = 0;
        do_reset(10'h000);
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && pops < 3; i++) begin
            if (mem_req === 1'b1 && req_cyc < 0) req_cyc = cyc;
            cycle();
        end
        total++;
        if (pops != 3 || last_pop_pc !== 10'h008) begin
            bad++; $display("FAIL zw_sequence: got pops=%0d last=%h want 3/008", pops, last_pop_pc);
        end
        total++;
        if (first_valid_cyc != req_cyc + 2) begin
            bad++; $display("FAIL zw_latency: got valid at %0d want %0d", first_valid_cyc, req_cyc + 2);
        end
        total++;
        if (adv_cycles.size() < 3) begin
            bad++; $display("FAIL zw_adv_count: got %0d want >=3", adv_cycles.size());
        end
        for (int i = 1; i < adv_cycles.size(); i++) begin
            total++;
            if (adv_cycles[i] - adv_cycles[i-1] != 2) begin
                bad++; $display("FAIL zw_adv_spacing: got %0d want 2", adv_cycles[i] - adv_cycles[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        max_gnt = 0; max_rv = 0;
        do_reset(10'h100);
        repeat (12) cycle();
        total++;
        if (grants != DEPTH || mem_req !== 1'b0) begin
            bad++; $display("FAIL bp_stall: got grants=%0d req=%b want %0d/0", grants, mem_req, DEPTH);
        end
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'h100) begin
            bad++; $display("FAIL bp_head: got valid=%b pc=%h want 1/100", instr_valid, instr_pc);
        end
        instr_ready = 1'b1; cycle(); instr_ready = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            cycle();
            if (mem_req === 1'b1) seen = 1'b1;
        end
        total++;
        if (pops != 1 || !seen) begin
            bad++; $display("FAIL bp_resume: got pops=%0d req_seen=%b want 1/1", pops, seen);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 30 && pops < 4; i++) cycle();
        total++;
        if (pops != 4 || last_pop_pc !== 10'h10C) begin
            bad++; $display("FAIL bp_order: got pops=%0d last=%h want 4/10c", pops, last_pop_pc);
        end
    endtask

    task automatic test_redirect_wait();
        max_gnt = 0; max_rv = 2;
        do_reset(10'h010);
        instr_ready = 1'b1;
        for (int i = 0; i < 10 && grants == 0; i++) cycle();
        rv_cnt = 2;
        total++;
        if (grants != 1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL rw_setup: got grants=%0d req=%b want 1/0", grants, mem_req);
        end
        redirect = 1'b1; redir_target = 10'h040;
        cycle();
        max_rv = 0;
        for (int i = 0; i < 20 && pops == 0; i++) cycle();
        total++;
        if (pops == 0 || last_pop_pc !== 10'h040) begin
            bad++; $display("FAIL rw_first_pc: got pops=%0d pc=%h want >0/040", pops, last_pop_pc);
        end
    endtask

    task automatic test_redirect_gnt();
        max_gnt = 0; max_rv = 1;
        do_reset(10'h020);
        instr_ready = 1'b1;
        for (int i = 0; i < 5 && mem_req !== 1'b1; i++) cycle();
        redirect = 1'b1; redir_target = 10'h080;
        cycle();
        total++;
        if (advs != 1 || grants != 1) begin
            bad++; $display("FAIL rg_grant: got advs=%0d grants=%0d want 1/1", advs, grants);
        end
        gnt_block = 1'b1;
        repeat (6) cycle();
        total++;
        if (instr_valid !== 1'b0 || pops != 0 || advs != 1) begin
            bad++; $display("FAIL rg_dropped: got valid=%b pops=%0d advs=%0d want 0/0/1", instr_valid, pops, advs);
        end
        gnt_block = 1'b0;
        for (int i = 0; i < 20 && pops == 0; i++) cycle();
        total++;
        if (pops == 0 || last_pop_pc !== 10'h080) begin
            bad++; $display("FAIL rg_next_pc: got pops=%0d pc=%h want >0/080", pops, last_pop_pc);
        end
    endtask

    task automatic test_misalign();
        max_gnt = 1; max_rv = 1;
        do_reset(10'h002);
        instr_ready = 1'b1;
        for (int i = 0; i < 10 && grants == 0; i++) cycle();
        total++;
        if (misalign !== 1'b1) begin
            bad++; $display("FAIL mis_set: got %b want 1", misalign);
        end
        redirect = 1'b1; redir_target = 10'h200;
        cycle();
        for (int i = 0; i < 60 && pops < 3; i++) cycle();
        total++;
        if (misalign !== 1'b1 || pops < 3 || last_pop_pc !== 10'h208) begin
            bad++; $display("FAIL mis_hold: got mis=%b pops=%0d last=%h want 1/3/208", misalign, pops, last_pop_pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        max_gnt = 0; max_rv = 3;
        do_reset(10'h302);
        instr_ready = 1'b1;
        for (int i = 0; i < 10 && grants == 0; i++) cycle();
        rv_cnt = 3;
        cycle();
        rst_n = 1'b0; pc_in = 10'h080;
        #1;
        check_all_zero("reset_mid_wait");
        pend = 1'b0; exp_pc = 10'h080; exp_mis = 1'b0; pops = 0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        stale_rv = 1'b1; cycle(); stale_rv = 1'b0;
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL rmw_stale: got valid=%b want 0", instr_valid);
        end
        max_rv = 0;
        for (int i = 0; i < 20 && pops == 0; i++) cycle();
        total++;
        if (pops == 0 || last_pop_pc !== 10'h080) begin
            bad++; $display("FAIL rmw_next_pc: got pops=%0d pc=%h want >0/080", pops, last_pop_pc);
        end
    endtask

    task automatic test_random();
        max_gnt = 3; max_rv = 3;
        do_reset(10'h000);
        for (int i = 0; i < 2000; i++) begin
            instr_ready = ($urandom_range(3) != 0);
            if ($urandom_range(19) == 0) begin
                redirect = 1'b1;
                redir_target = PC_W'($urandom_range(255) << 2);
            end
            cycle();
        end
        total++;
        if (pops < 100) begin
            bad++; $display("FAIL rnd_progress: got pops=%0d want >=100", pops);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_misalign();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
